// File: rtl/icap_writer.sv
// icap_writer: drains the 32-bit configuration stream into ICAP with per-byte bit reversal,
// framing each bitstream by tlast and reporting word count, keep errors and completion.
module icap_writer #(
  parameter int TAIL_CYCLES = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 en,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic [31:0]          s_axis_tdata,
  input  logic [3:0]           s_axis_tkeep,
  input  logic                 s_axis_tlast,
  output logic                 icap_csib,
  output logic                 icap_rdwrb,
  output logic [31:0]          icap_i,
  output logic                 busy,
  output logic                 done,
  output logic                 err_keep,
  output logic [CNT_WIDTH-1:0] word_cnt
);
  typedef enum logic [1:0] {IDLE, ARM, WRITE, TAIL} state_t;
  state_t state_q, state_d;
  logic csib_q, csib_d, rdwrb_q, rdwrb_d, busy_q, done_q, done_d, err_q, err_d;
  logic [31:0] data_q, data_d, swapped;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0] tail_q, tail_d;
  logic beat, good;
  for (genvar b = 0; b < 32; b++) begin : g_swap
    assign swapped[b] = s_axis_tdata[b / 8 * 8 + 7 - b % 8];
  end
  assign s_axis_tready = state_q == WRITE;
  assign beat = s_axis_tvalid && s_axis_tready;
  assign good = s_axis_tkeep == 4'hF;
  always_comb begin
    state_d = state_q;
    csib_d  = 1'b1;
    rdwrb_d = rdwrb_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    tail_d  = tail_q;
    case (state_q)
      IDLE: if (en) begin
        state_d = ARM;
        rdwrb_d = 1'b0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      ARM: begin
        state_d = WRITE;
        tail_d  = 8'd0;
      end
      WRITE: if (beat) begin
        csib_d  = !good;
        data_d  = good ? swapped : data_q;
        cnt_d   = (good && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
        err_d   = err_q || !good;
        state_d = s_axis_tlast ? TAIL : WRITE;
      end
      TAIL: begin
        tail_d = tail_q + 8'd1;
        // the entry cycle still shows the last write, so TAIL_CYCLES idle cycles follow it
        if (tail_q == 8'(TAIL_CYCLES)) begin
          rdwrb_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      csib_q  <= 1'b1;
      rdwrb_q <= 1'b1;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tail_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      csib_q  <= csib_d;
      rdwrb_q <= rdwrb_d;
      data_q  <= data_d;
      busy_q  <= state_d != IDLE;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
    end
  end
  assign icap_csib  = csib_q;
  assign icap_rdwrb = rdwrb_q;
  assign icap_i     = data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_keep   = err_q;
  assign word_cnt   = cnt_q;
endmodule

// File: tb/tb_icap_writer.sv
// tb_icap_writer: random frames checked against a queue-based model of the ICAP write stream,
// with a CNT_WIDTH=4 instance sharing the stimulus to exercise counter saturation.
module tb_icap_writer;
  localparam int TAIL = 4;
  logic clk = 0, resetn = 0, en = 0, tvalid = 0, tlast = 0;
  logic [31:0] tdata = '0;
  logic [3:0] tkeep = '0;
  logic tready, csib, rdwrb, busy, done, err;
  logic [31:0] icap, cnt;
  logic s_tready, s_csib, s_rdwrb, s_busy, s_done, s_err;
  logic [31:0] s_icap;
  logic [3:0] s_cnt;
  int checks = 0, failures = 0;
  logic [31:0] words [64];
  logic [3:0] keeps [64];
  logic [31:0] exp_q [$];
  logic [31:0] e;
  int exp_cnt, cyc, hs_cyc, done_cyc, done_n;
  bit exp_err, want, prev_done, prev_busy, after_done;
  icap_writer #(.TAIL_CYCLES(TAIL)) u_dut (
    .clk(clk), .resetn(resetn), .en(en), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .icap_csib(csib),
    .icap_rdwrb(rdwrb), .icap_i(icap), .busy(busy), .done(done), .err_keep(err), .word_cnt(cnt)
  );
  icap_writer #(.TAIL_CYCLES(TAIL), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .resetn(resetn), .en(en), .s_axis_tvalid(tvalid), .s_axis_tready(s_tready),
    .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tlast(tlast), .icap_csib(s_csib),
    .icap_rdwrb(s_rdwrb), .icap_i(s_icap), .busy(s_busy), .done(s_done), .err_keep(s_err),
    .word_cnt(s_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rev_bytes(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 8; j++) r[8*k+j] = w[8*k+7-j];
    return r;
  endfunction
  // A good accepted beat must appear on ICAP exactly one cycle later; anything else keeps csib high.
  always @(negedge clk) begin
    cyc++;
    if (resetn) begin
      check("csib", csib, !want);
      if (want) begin
        check("rdwrb_in_write", rdwrb, 0);
        e = exp_q.size() ? exp_q.pop_front() : 32'hx;
        check("icap_data", icap, e);
        check("sat_icap_data", s_icap, e);
        if (after_done) check("rearm_gap", cyc - done_cyc >= 3, 1);
        after_done = 0;
      end
      if (!busy) check("tready_idle", tready, 0);
      if (busy && !prev_busy) begin
        check("arm_rdwrb", rdwrb, 0);
        check("arm_csib", csib, 1);
      end
      if (prev_done) check("done_width", done, 0);
      if (done) begin
        check("tail_len", cyc - hs_cyc, TAIL + 2);
        check("done_rdwrb", rdwrb, 1);
        check("word_cnt", cnt, exp_cnt);
        check("sat_word_cnt", s_cnt, exp_cnt > 15 ? 15 : exp_cnt);
        check("err_keep", err, exp_err);
        check("sat_done", s_done, 1);
        check("all_written", exp_q.size(), 0);
        done_n++;
        done_cyc = cyc;
        after_done = 1;
      end
      want = tvalid && tready && tkeep == 4'hF;
      if (tvalid && tready) begin
        if (tkeep == 4'hF) begin
          exp_q.push_back(rev_bytes(tdata));
          exp_cnt++;
        end else exp_err = 1;
        if (tlast) hs_cyc = cyc;
      end
      prev_done = done;
      prev_busy = busy;
    end else begin
      want = 0;
      prev_done = 0;
      prev_busy = 0;
    end
  end
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      words[i] = $urandom;
      keeps[i] = 4'hF;
    end
  endtask
  task automatic send_frame(input int n, input int gap, input int en_drop_after, input int rst_after);
    int t, d0;
    bit hs;
    exp_cnt = 0;
    exp_err = 0;
    en = 1;
    for (int i = 0; i < n; i++) begin
      tvalid = 1;
      tdata = words[i];
      tkeep = keeps[i];
      tlast = i == n - 1;
      t = 0;
      do begin
        hs = tready;
        @(posedge clk);
        #1;
        t++;
      end while (!hs && t < 50);
      tvalid = 0;
      tlast = 0;
      if (!hs) begin
        check("handshake_timeout", 0, 1);
        return;
      end
      if (i + 1 == en_drop_after) en = 0;
      if (i + 1 == rst_after) begin
        @(negedge clk);
        #2;
        d0 = done_n;
        en = 0;
        resetn = 0;
        #1;
        check("rst_csib", csib, 1);
        check("rst_rdwrb", rdwrb, 1);
        check("rst_busy", busy, 0);
        check("rst_tready", tready, 0);
        check("rst_cnt", cnt, 0);
        exp_q.delete();
        after_done = 0;
        repeat (2) @(posedge clk);
        #2 resetn = 1;
        repeat (10) @(posedge clk);
        #1 check("rst_no_done", done_n, d0);
        return;
      end
      repeat (gap >= 0 ? gap : $urandom_range(2)) begin
        @(posedge clk);
        #1;
      end
    end
    d0 = done_n;
    t = 0;
    while (done_n == d0 && t < 60) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("done_seen", done_n != d0, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_csib0", csib, 1);
    check("rst_rdwrb0", rdwrb, 1);
    check("rst_icap0", icap, 0);
    check("rst_tready0", tready, 0);
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_err0", err, 0);
    check("rst_cnt0", cnt, 0);
    #1 resetn = 1;
    tvalid = 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      check("idle_tready", tready, 0);
      check("idle_csib", csib, 1);
    end
    tvalid = 0;
    fill(2);
    words[0] = 32'hFFFFFFFF;
    words[1] = 32'hAA995566;
    send_frame(2, 0, -1, -1);
    fill(3);
    send_frame(3, 2, -1, -1);
    fill(4);
    keeps[1] = 4'h7;
    send_frame(4, 0, -1, -1);
    fill(5);
    send_frame(5, -1, 1, -1);
    repeat (3) @(posedge clk);
    #1;
    check("cnt_hold", cnt, 5);
    check("err_hold", err, 0);
    check("idle_after_done", busy, 0);
    fill(5);
    send_frame(5, 0, -1, 2);
    fill(1);
    keeps[0] = 4'h3;
    send_frame(1, 0, -1, -1);
    fill(20);
    send_frame(20, 0, -1, -1);
    for (int f = 0; f < 6; f++) begin
      int n;
      n = $urandom_range(8, 1);
      fill(n);
      for (int i = 0; i < n; i++) if ($urandom_range(5) == 0) keeps[i] = 4'($urandom_range(14));
      send_frame(n, -1, -1, -1);
    end
    en = 0;
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/icap_writer.md
Name: icap_writer

Overview:
- Consumer end of the configuration path. Takes the narrow 32-bit AXI-Stream produced by the configuration buffer and writes it into the FPGA ICAP primitive.
- Sequences ICAP CSIB/RDWRB and applies the per-byte bit swap that ICAP requires.
- Frames each bitstream by tlast, counts the words written, and reports done/error status to the control registers.

Parameters:
- TAIL_CYCLES, 4: idle cycles with CSIB high after the last word, before RDWRB is released and done is pulsed; legal range 1..255.
- CNT_WIDTH, 32: width of the written-word counter.

Ports:
- clk  input  1  block clock, also the ICAP clock.
- resetn  input  1  asynchronous reset, active low.
- en  input  1  arm request; sampled only in IDLE.
- s_axis_tvalid  input  1  stream word valid.
- s_axis_tready  output  1  stream word accepted.
- s_axis_tdata  input  32  bitstream word, byte 3 first on the wire.
- s_axis_tkeep  input  4  byte enables; only 4'hF is legal.
- s_axis_tlast  input  1  last word of the bitstream.
- icap_csib  output  1  ICAP chip select, active low.
- icap_rdwrb  output  1  ICAP direction; 0 = write.
- icap_i  output  32  ICAP write data, bit-swapped.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at the end of a frame.
- err_keep  output  1  sticky: at least one word had tkeep != 4'hF.
- word_cnt  output  CNT_WIDTH  words written to ICAP in the current or last frame; saturates.

Behaviour:
- Clock/reset: one clock, clk. Reset resetn is asynchronous, active low. All ICAP outputs and all status outputs are registered.
- Reset values: icap_csib=1, icap_rdwrb=1, icap_i=0, s_axis_tready=0, busy=0, done=0, err_keep=0, word_cnt=0, state=IDLE.
- Bit swap: icap_i[8k+j] = tdata[8k+7-j] for k=0..3, j=0..7. Each byte is reversed; byte order is unchanged.
- IDLE: tready=0, csib=1, rdwrb=1. en=1 → ARM; on this transition word_cnt and err_keep clear.
- ARM: one cycle. rdwrb<=0 while csib stays 1, so RDWRB never changes while CSIB is low. → WRITE.
- WRITE: tready=1 combinationally.
  - Beat accepted with tkeep=4'hF: next cycle csib=0 and icap_i=swap(tdata), giving 1-cycle latency; word_cnt+1, saturating at all-ones.
  - Beat accepted with tkeep!=4'hF: word is dropped, csib=1 next cycle, err_keep<=1, word_cnt unchanged.
  - No beat accepted: csib<=1 and icap_i holds its previous value.
  - Accepted beat with tlast=1: written or dropped per the rules above, then → TAIL.
- TAIL: tready=0, csib=1. Counts TAIL_CYCLES cycles. On the final count: rdwrb<=1, done<=1 for 1 cycle → IDLE.
- en is ignored outside IDLE. Deasserting en mid-frame does not abort the frame; the frame ends only on tlast.
- en held high: a new frame arms on the cycle after the return to IDLE, i.e. a minimum gap of 2 cycles between done and the next csib=0.
- Back-to-back beats: one ICAP write per cycle. csib stays low continuously across consecutive accepted words.
- Zero-length frame is not possible: tlast always accompanies a beat.
- A single-word frame with bad tkeep gives word_cnt=0, err_keep=1 and still pulses done.
- Reset mid-frame: immediately csib=1 and rdwrb=1. No done pulse. Stream words still in flight upstream are the upstream block's concern.
- Status: word_cnt and err_keep hold after done until the next arm.

Test Plan:
- Reset then idle: outputs at their reset values. tvalid=1 with en=0 for 10 cycles → tready=0, csib=1 throughout.
- Sync word: en=1, then frame {0xFFFFFFFF, 0xAA995566 (tlast)} back-to-back.
  - ARM cycle: rdwrb=0, csib=1.
  - Two consecutive csib=0 cycles with icap_i = 0xFFFFFFFF then 0x5599AA66.
  - 4 cycles csib=1, then rdwrb=1 and a 1-cycle done; word_cnt=2, err_keep=0.
- Gapped stream: 3 words with tvalid low for 2 cycles between each → csib low exactly 3 single cycles, icap_i correct for each, word_cnt=3.
- Bad keep: 4-word frame, word 2 with tkeep=4'h7 → only 3 csib=0 cycles, word 2 never on icap_i, err_keep=1, word_cnt=3, done pulses.
- Mid-frame en drop and reset:
  - en deasserted after word 1 of a 5-word frame → all 5 words written, done pulses.
  - Repeat with resetn pulsed low after word 2 → csib=1 and rdwrb=1 asynchronously, no done, busy=0.
- Saturation: CNT_WIDTH=4 build, 20-word frame → word_cnt stays at 15 and all 20 words reach ICAP.
